ctr_keystream_xor: RTL and testbench
====================================

Name: ctr_keystream_xor

Overview:
Output stage of the AES-CTR datapath.
- Accepts plaintext/ciphertext blocks and issues one counter block {nonce, ctr} per accepted block to the cipher pipeline, which ends in the final round.
- Buffers the data until the matching keystream returns in order, XORs the two, and presents the result on a valid/ready output.
- Joins the design's scan chain through its counter register.

Parameters:
DEPTH, 4, maximum blocks in flight plus buffered results; power of two, 2..16
CTR_W, 32, counter width; NONCE_W = 128 - CTR_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
scan_input  in  1  scan chain serial in
scan_output  out  1  scan chain serial out, = ctr[CTR_W-1]
scan_ck_en  in  1  scan shift enable, valid while scan_enable=1
scan_enable  in  1  scan mode; freezes all functional state
nonce  in  NONCE_W  static nonce; sampled on each accept
ctr_load  in  1  load counter from ctr_init
ctr_init  in  CTR_W  initial counter value
din_valid  in  1  input block valid
din_ready  out  1  input block accepted when din_valid and din_ready are both 1
din  in  128  data block
blk_out  out  128  counter block to cipher, {nonce, ctr}
blk_start  out  1  one-cycle pulse; blk_out valid
ks_valid  in  1  keystream block valid, in issue order
ks  in  128  keystream block from final round
dout_valid  out  1  result valid
dout_ready  in  1  result consumed when dout_valid and dout_ready are both 1
dout  out  128  din XOR ks
err  out  1  sticky: ks_valid with nothing in flight

Behaviour:
Reset (rst_n=0, asynchronous):
- ctr=0, blk_out=0, blk_start=0, err=0; both FIFOs empty; inflight=0.
- dout_valid=0, din_ready=0 while rst_n=0.

din_ready = !scan_enable && !ctr_load && (inflight + res_count < DEPTH).
- This credit rule guarantees a result slot for every in-flight block, because the cipher cannot stall.

Accept (din_valid && din_ready):
- din is pushed to the data FIFO.
- Next cycle: blk_out={nonce, ctr}, blk_start=1.
- ctr <= ctr+1 modulo 2^CTR_W; 32'hFFFF_FFFF wraps to 0, no flag.
- inflight += 1.

blk_start:
- High exactly one cycle per accept; back-to-back accepts give consecutive pulses.
- blk_out holds its value when blk_start=0.

Load (ctr_load=1, scan_enable=0):
- ctr <= ctr_init; din_ready=0 that cycle, so there is never a conflict with increment.
- In-flight blocks are unaffected.

Keystream return (ks_valid=1, scan_enable=0):
- If inflight>0: pop data FIFO head, push (head ^ ks) to the result FIFO, inflight -= 1.
- If inflight=0: ks is dropped, err <= 1. err clears only on reset.

Output:
- dout = result FIFO head; dout_valid = (res_count>0) && !scan_enable.
- Pop on handshake; dout stays stable while dout_valid && !dout_ready.

Simultaneous events in one cycle:
- Accept, ks return and output pop may all occur.
- inflight += accept - ks; res_count += ks - pop, computed from the pre-cycle values.
- The credit check uses the pre-cycle counts; a pop does not create same-cycle credit.

Latency:
- Accept to blk_start: 1 cycle.
- ks_valid to dout_valid: 1 cycle when the result FIFO is empty.

Scan (scan_enable=1):
- All functional state is frozen; blk_start=0, din_ready=0, dout_valid=0; ks_valid is ignored and err is not set.
- With scan_ck_en=1: ctr <= {ctr[CTR_W-2:0], scan_input}; scan_output=ctr[CTR_W-1].
- With scan_ck_en=0: ctr holds.
- The FIFOs are not on the chain.

Decomposition:
- Package aes_ctr_pkg: BLOCK_W=128, CTR_W default, NONCE_W, and the credit-count width function clog2(DEPTH+1).
- Sub-module sync_fifo (WIDTH, DEPTH): instantiated twice, as the data FIFO and the result FIFO.
  - sync_fifo has the same clk/rst_n, push/pop/full/empty/count ports, first-word fall-through.
  - Push to full and pop from empty are assertion failures; they are unreachable by the credit rule.

Test Plan:
- Single block: ctr_load ctr_init=5, nonce=96'hA5..A5, accept din=128'h0 → next cycle blk_out={nonce,32'h5}, blk_start=1; ks=128'h1234 returned → dout=128'h1234 one cycle later, then ctr=6.
- Credit full, DEPTH=4: accept 4 blocks, no ks → din_ready=0; return 1 ks with dout_ready=0 → din_ready stays 0; pop dout → din_ready=1 the next cycle.
- Wrap: ctr_init=32'hFFFF_FFFF, accept 2 → blk_out counters FFFF_FFFF then 0000_0000; order of dout matches din order.
- Simultaneous: inflight=2, res_count=1; in one cycle, accept + ks_valid + dout pop → inflight=2, res_count=1, no data lost; 16-block random-stall run checks dout[i] = din[i]^ks[i].
- Spurious ks: ks_valid with inflight=0 → err=1, no dout_valid; err stays 1 until rst_n=0.
- Scan and reset: scan_enable=1, shift in 32'hDEAD_BEEF over 32 cycles → scan_output emits the prior ctr MSB-first, ctr=DEAD_BEEF, no blk_start; rst_n low mid-traffic → all outputs 0 immediately, FIFOs empty.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_ctr_pkg: shared widths and helpers for the AES-CTR output stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
package aes_ctr_pkg;

  localparam int BLOCK_W     = 128;
  localparam int CTR_W_DEF   = 32;
  localparam int NONCE_W_DEF = BLOCK_W - CTR_W_DEF;

  // Counts run 0..DEPTH inclusive, so they need one more code than DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo: first-word fall-through FIFO with occupancy count.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync_fifo
  import aes_ctr_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctr_keystream_xor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctr_keystream_xor: AES-CTR output stage; issues {nonce, ctr} blocks and
// XORs buffered data with the in-order keystream. Revision: 1.0
// ----------------------------------------------------------------------------
module ctr_keystream_xor
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scan_input,
  output logic                     scan_output,
  input  logic                     scan_ck_en,
  input  logic                     scan_enable,
  input  logic [BLOCK_W-CTR_W-1:0] nonce,
  input  logic                     ctr_load,
  input  logic [CTR_W-1:0]         ctr_init,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [BLOCK_W-1:0]       din,
  output logic [BLOCK_W-1:0]       blk_out,
  output logic                     blk_start,
  input  logic                     ks_valid,
  input  logic [BLOCK_W-1:0]       ks,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [BLOCK_W-1:0]       dout,
  output logic                     err
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [CTR_W-1:0]   ctr;
  logic               blk_start_q;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   res_count;
  logic [CNT_W:0]     credit_used;
  logic [BLOCK_W-1:0] data_head;
  logic               res_empty;
  logic               accept;
  logic               ks_take;
  logic               ks_spurious;
  logic               res_pop;
  logic               data_full;
  logic               data_empty;
  logic               res_full;
  logic               unused_fifo_flags;

  assign unused_fifo_flags = data_full ^ data_empty ^ res_full;

  // Result slots are reserved at accept time because the cipher cannot stall.
  assign credit_used = {1'b0, inflight} + {1'b0, res_count};
  assign din_ready   = rst_n && !scan_enable && !ctr_load &&
                       (credit_used < (CNT_W + 1)'(DEPTH));
  assign accept      = din_valid && din_ready;
  assign ks_take     = ks_valid && !scan_enable && (inflight != '0);
  assign ks_spurious = ks_valid && !scan_enable && (inflight == '0);
  assign dout_valid  = rst_n && !res_empty && !scan_enable;
  assign res_pop     = dout_valid && dout_ready;
  assign blk_start   = blk_start_q && !scan_enable;
  assign scan_output = ctr[CTR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr         <= '0;
      blk_out     <= '0;
      blk_start_q <= 1'b0;
      err         <= 1'b0;
    end else if (scan_enable) begin
      blk_start_q <= 1'b0;
      if (scan_ck_en) begin
        ctr <= {ctr[CTR_W-2:0], scan_input};
      end
    end else begin
      blk_start_q <= accept;
      if (accept) begin
        blk_out <= {nonce, ctr};
        ctr     <= ctr + CTR_W'(1);
      end else if (ctr_load) begin
        ctr <= ctr_init;
      end
      if (ks_spurious) begin
        err <= 1'b1;
      end
    end
  end

  // The data FIFO holds exactly the blocks awaiting keystream, so its
  // occupancy is the in-flight count.
  sync_fifo #(
    .WIDTH(BLOCK_W),
    .DEPTH(DEPTH)
  ) u_data_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (accept),
    .wdata(din),
    .pop  (ks_take),
    .rdata(data_head),
    .full (data_full),
    .empty(data_empty),
    .count(inflight)
  );

  sync_fifo #(
    .WIDTH(BLOCK_W),
    .DEPTH(DEPTH)
  ) u_res_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (ks_take),
    .wdata(data_head ^ ks),
    .pop  (res_pop),
    .rdata(dout),
    .full (res_full),
    .empty(res_empty),
    .count(res_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ctr_keystream_xor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ctr_keystream_xor: directed self-checking bench for ctr_keystream_xor.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ctr_keystream_xor;

  logic         clk = 1'b0;
  logic         rst_n, scan_input, scan_ck_en, scan_enable, ctr_load;
  logic         din_valid, ks_valid, dout_ready;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic [127:0] din, ks;
  logic         scan_output, din_ready, blk_start, dout_valid, err;
  logic [127:0] blk_out, dout;

  int checks = 0;
  int errors = 0;

  ctr_keystream_xor #(.DEPTH(4), .CTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .scan_input(scan_input), .scan_output(scan_output),
    .scan_ck_en(scan_ck_en), .scan_enable(scan_enable), .nonce(nonce),
    .ctr_load(ctr_load), .ctr_init(ctr_init), .din_valid(din_valid),
    .din_ready(din_ready), .din(din), .blk_out(blk_out), .blk_start(blk_start),
    .ks_valid(ks_valid), .ks(ks), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] d [5];
  logic [127:0] k [5];
  logic [127:0] din_q [$];
  logic [127:0] exp_q [$];
  logic [31:0]  prior, pattern;
  int           sent, recv, infl;
  bit           acc, pop;

  initial begin
    rst_n = 1'b0; scan_input = 1'b0; scan_ck_en = 1'b0; scan_enable = 1'b0;
    ctr_load = 1'b0; ctr_init = '0; din_valid = 1'b0; ks_valid = 1'b0;
    dout_ready = 1'b0; din = '0; ks = '0; nonce = {12{8'hA5}};
    for (int i = 0; i < 5; i++) begin
      d[i] = rnd128();
      k[i] = rnd128();
    end

    // Reset state
    tick();
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_blk_start", blk_start, 0);
    chk("rst_blk_out", blk_out, 0);
    chk("rst_err", err, 0);
    chk("rst_scan_out", scan_output, 0);
    tick();
    rst_n = 1'b1;

    // Single block
    ctr_load = 1'b1; ctr_init = 32'd5;
    #1 chk("load_blocks_ready", din_ready, 0);
    tick();
    ctr_load = 1'b0; din_valid = 1'b1; din = '0;
    #1 chk("single_ready", din_ready, 1);
    tick();
    din_valid = 1'b0;
    chk("single_blk_start", blk_start, 1);
    chk("single_blk_out", blk_out, {nonce, 32'h5});
    tick();
    chk("single_blk_start_low", blk_start, 0);
    chk("single_blk_out_hold", blk_out, {nonce, 32'h5});
    ks_valid = 1'b1; ks = 128'h1234;
    #1 chk("single_no_dout_yet", dout_valid, 0);
    tick();
    ks_valid = 1'b0;
    #1 chk("single_dout_valid", dout_valid, 1);
    chk("single_dout", dout, 128'h1234);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    #1 chk("single_drained", dout_valid, 0);

    // Credit full: four accepts, counters 6..9
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = d[i];
      tick();
      chk("credit_blk_start", blk_start, 1);
      chk("credit_blk_out", blk_out, {nonce, 32'(6 + i)});
    end
    din_valid = 1'b0;
    #1 chk("credit_full", din_ready, 0);
    ks_valid = 1'b1; ks = k[0];
    tick();
    ks_valid = 1'b0;
    #1 chk("credit_dout0", dout, d[0] ^ k[0]);
    chk("credit_still_full", din_ready, 0);
    tick();
    chk("credit_dout_stable", dout, d[0] ^ k[0]);
    chk("credit_valid_stable", dout_valid, 1);
    dout_ready = 1'b1;
    #1 chk("credit_pop_no_same_cycle", din_ready, 0);
    tick();
    dout_ready = 1'b0;
    #1 chk("credit_freed", din_ready, 1);
    chk("credit_res_empty", dout_valid, 0);
    ks_valid = 1'b1; ks = k[1];
    tick();

    // Simultaneous accept + ks + pop with inflight=2, res_count=1
    din_valid = 1'b1; din = d[4]; ks = k[2]; dout_ready = 1'b1;
    #1 chk("sim_ready", din_ready, 1);
    chk("sim_dout1", dout, d[1] ^ k[1]);
    tick();
    din_valid = 1'b0; ks_valid = 1'b0; dout_ready = 1'b0;
    #1 chk("sim_blk_out", blk_out, {nonce, 32'd10});
    chk("sim_dout2", dout, d[2] ^ k[2]);
    chk("sim_ready_after", din_ready, 1);
    ks_valid = 1'b1; ks = k[3]; dout_ready = 1'b1;
    tick();
    #1 chk("sim_dout3", dout, d[3] ^ k[3]);
    ks = k[4];
    tick();
    ks_valid = 1'b0;
    #1 chk("sim_dout4", dout, d[4] ^ k[4]);
    tick();
    dout_ready = 1'b0;
    #1 chk("sim_drained", dout_valid, 0);

    // Counter wrap
    ctr_load = 1'b1; ctr_init = 32'hFFFF_FFFF;
    tick();
    ctr_load = 1'b0; din_valid = 1'b1; din = d[0];
    tick();
    chk("wrap_blk_ffff", blk_out, {nonce, 32'hFFFF_FFFF});
    din = d[1];
    tick();
    din_valid = 1'b0;
    chk("wrap_blk_zero", blk_out, {nonce, 32'h0});
    ks_valid = 1'b1; ks = k[0];
    tick();
    ks = k[1];
    tick();
    ks_valid = 1'b0;
    #1 chk("wrap_dout0", dout, d[0] ^ k[0]);
    dout_ready = 1'b1;
    tick();
    #1 chk("wrap_dout1", dout, d[1] ^ k[1]);
    tick();
    dout_ready = 1'b0;
    #1 chk("wrap_drained", dout_valid, 0);

    // 16-block random-stall run
    sent = 0; recv = 0; infl = 0;
    for (int cyc = 0; cyc < 3000 && recv < 16; cyc++) begin
      din_valid  = (sent < 16) && ($urandom_range(0, 1) == 1);
      din        = rnd128();
      ks_valid   = (infl > 0) && ($urandom_range(0, 2) != 0);
      ks         = rnd128();
      dout_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = din_valid && din_ready;
      pop = dout_valid && dout_ready;
      if (pop) begin
        if (exp_q.size() > 0) chk("rand_dout", dout, exp_q.pop_front());
        else chk("rand_unexpected_dout", dout_valid, 0);
      end
      tick();
      if (ks_valid) begin
        exp_q.push_back(din_q.pop_front() ^ ks);
        infl--;
      end
      if (acc) begin
        din_q.push_back(din);
        infl++;
        sent++;
      end
      if (pop) recv++;
    end
    din_valid = 1'b0; ks_valid = 1'b0; dout_ready = 1'b0;
    chk("rand_recv", recv, 16);

    // Scan shift: ks_valid and din_valid must be ignored throughout
    ctr_load = 1'b1; ctr_init = 32'h1357_9BDF; prior = 32'h1357_9BDF;
    tick();
    ctr_load = 1'b0;
    pattern = 32'hDEAD_BEEF;
    scan_enable = 1'b1; scan_ck_en = 1'b1; din_valid = 1'b1; ks_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      scan_input = pattern[31-i];
      #1;
      chk("scan_out", scan_output, prior[31-i]);
      chk("scan_din_ready", din_ready, 0);
      chk("scan_blk_start", blk_start, 0);
      tick();
    end
    scan_ck_en = 1'b0;
    #1 chk("scan_msb", scan_output, 1);
    tick();
    chk("scan_hold", scan_output, 1);
    chk("scan_no_err", err, 0);
    chk("scan_dout_valid", dout_valid, 0);
    scan_enable = 1'b0; ks_valid = 1'b0; din = d[2];
    tick();
    din_valid = 1'b0;
    chk("scan_ctr_loaded", blk_out, {nonce, 32'hDEAD_BEEF});
    ks_valid = 1'b1; ks = k[2];
    tick();
    ks_valid = 1'b0;
    #1 chk("scan_after_dout", dout, d[2] ^ k[2]);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Spurious keystream
    ks_valid = 1'b1; ks = k[3];
    tick();
    ks_valid = 1'b0;
    #1 chk("spur_err", err, 1);
    chk("spur_no_dout", dout_valid, 0);
    tick();
    chk("spur_err_sticky", err, 1);

    // Asynchronous reset mid-traffic
    din_valid = 1'b1; din = d[0];
    tick();
    din = d[1];
    tick();
    din_valid = 1'b0; ks_valid = 1'b1; ks = k[0];
    tick();
    ks_valid = 1'b0;
    #1 chk("mid_dout_pending", dout_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dout_valid", dout_valid, 0);
    chk("arst_din_ready", din_ready, 0);
    chk("arst_blk_out", blk_out, 0);
    chk("arst_blk_start", blk_start, 0);
    chk("arst_err", err, 0);
    chk("arst_scan_out", scan_output, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_empty", dout_valid, 0);
    chk("post_rst_ready", din_ready, 1);
    ks_valid = 1'b1;
    tick();
    ks_valid = 1'b0;
    #1 chk("post_rst_inflight_zero", err, 1);
    chk("post_rst_no_dout", dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
